// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer
//  Description : Game-flow controller for the Flappy Bird VGA design.
//                Debounces the start/flap buttons, runs the
//                IDLE/PLAY/DYING/OVER state machine, issues single-cycle
//                move-tick enables and object resets, and keeps the
//                current and best scores in BCD.
//  Ports       : clk         - system clock
//                rst         - asynchronous reset, active low
//                btn_start   - raw start/restart button (asynchronous)
//                btn_flap    - raw flap button (asynchronous)
//                collide     - bird overlap level (synchronous)
//                pipe_passed - one-cycle pulse when a pipe passes the bird
//                move_en     - one-cycle move tick for object controllers
//                flap        - one-cycle flap command (PLAY only)
//                freeze      - high when pipes must not move
//                objs_rst    - reset to block/pipe controllers (IDLE)
//                state       - 00 IDLE, 01 PLAY, 10 DYING, 11 OVER
//                score_bcd   - current score, 4 BCD digits
//                best_bcd    - best score since reset, 4 BCD digits
//  Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer #(
    parameter int TICK_DIV    = 1048576,
    parameter int DEB_CYCLES  = 500000,
    parameter int DEATH_TICKS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_flap,
    input  logic        collide,
    input  logic        pipe_passed,
    output logic        move_en,
    output logic        flap,
    output logic        freeze,
    output logic        objs_rst,
    output logic [1:0]  state,
    output logic [15:0] score_bcd,
    output logic [15:0] best_bcd
);

    localparam int c_tick_w  = $clog2(TICK_DIV);
    localparam int c_deb_w   = $clog2(DEB_CYCLES);
    localparam int c_death_w = $clog2(DEATH_TICKS + 1);

    localparam logic [c_tick_w-1:0]  c_tick_last  = c_tick_w'(TICK_DIV - 1);
    localparam logic [c_deb_w-1:0]   c_deb_last   = c_deb_w'(DEB_CYCLES - 1);
    localparam logic [c_death_w-1:0] c_death_last = c_death_w'(DEATH_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_DYING = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    // BCD +1 with per-digit carry, holding at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] res;
        logic        carry;
        res   = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int d = 0; d < 4; d++) begin
                if (carry) begin
                    if (res[4*d +: 4] == 4'd9) begin
                        res[4*d +: 4] = 4'd0;
                    end else begin
                        res[4*d +: 4] = res[4*d +: 4] + 4'd1;
                        carry         = 1'b0;
                    end
                end
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    // r_live goes high once the synchronizers hold genuine input samples,
    // so a button can only be armed by a real released level. A button
    // held through reset therefore never arms until it is let go, and its
    // first debounced rise after reset is not reported as a press.
    logic [1:0] r_live;
    logic       w_live;
    logic [1:0] w_btn_raw;
    logic [1:0] w_press;
    logic       w_start_p;
    logic       w_flap_p;

    assign w_live    = r_live[1];
    assign w_btn_raw = {btn_flap, btn_start};
    assign w_start_p = w_press[0];
    assign w_flap_p  = w_press[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live <= 2'b00;
        end else begin
            r_live <= {r_live[0], 1'b1};
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic               r_deb;
        logic               r_deb_d;
        logic               r_armed;
        logic               r_press;
        logic [c_deb_w-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_deb   <= 1'b0;
                r_deb_d <= 1'b0;
                r_armed <= 1'b0;
                r_press <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_btn_raw[gi];
                r_sync2 <= r_sync1;
                // Count consecutive disagreeing cycles; any agreement restarts.
                if (r_sync2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_deb_last) begin
                    r_deb <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_armed <= r_armed | (w_live & ~r_sync2 & ~r_deb);
                r_deb_d <= r_deb;
                r_press <= r_armed & r_deb & ~r_deb_d;
            end
        end

        assign w_press[gi] = r_press;
    end

    // ------------------------------------------------------------------
    // Free-running tick, state machine, score
    // ------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_tick_w-1:0]    r_tick_cnt;
    logic [c_death_w-1:0]   r_death_cnt;
    logic                   w_tick;
    logic                   r_move_en;
    logic                   r_flap;
    logic                   r_freeze;
    logic                   r_objs_rst;
    logic [15:0]            r_score;
    logic [15:0]            r_best;

    assign w_tick = (r_tick_cnt == c_tick_last);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_p || w_flap_p) w_state_next = ST_PLAY;
            ST_PLAY:  if (collide) w_state_next = ST_DYING;
            ST_DYING: if (w_tick && (r_death_cnt == c_death_last)) w_state_next = ST_OVER;
            ST_OVER:  if (w_start_p) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_tick_cnt  <= '0;
            r_death_cnt <= '0;
            r_move_en   <= 1'b0;
            r_flap      <= 1'b0;
            r_freeze    <= 1'b1;
            r_objs_rst  <= 1'b1;
            r_score     <= 16'h0000;
            r_best      <= 16'h0000;
        end else begin
            r_state    <= w_state_next;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;

            // Held at zero outside DYING, so it is clear on every DYING
            // entry; the tick of the entry cycle is seen in PLAY and ignored.
            if (r_state != ST_DYING) begin
                r_death_cnt <= '0;
            end else if (w_tick) begin
                r_death_cnt <= r_death_cnt + 1'b1;
            end

            r_move_en  <= w_tick & ((r_state == ST_PLAY) || (r_state == ST_DYING));
            r_flap     <= w_flap_p & (r_state == ST_PLAY);
            // Derived from the next state so they change with the state output.
            r_freeze   <= (w_state_next != ST_PLAY);
            r_objs_rst <= (w_state_next == ST_IDLE);

            // A collision in the same cycle as a pipe pass forfeits the point.
            if ((r_state == ST_IDLE) && (w_state_next == ST_PLAY)) begin
                r_score <= 16'h0000;
            end else if ((r_state == ST_PLAY) && pipe_passed && !collide) begin
                r_score <= bcd_inc(r_score);
            end

            // Packed BCD orders the same as binary.
            if ((r_state == ST_DYING) && (w_state_next == ST_OVER) && (r_score > r_best)) begin
                r_best <= r_score;
            end
        end
    end

    assign move_en   = r_move_en;
    assign flap      = r_flap;
    assign freeze    = r_freeze;
    assign objs_rst  = r_objs_rst;
    assign state     = r_state;
    assign score_bcd = r_score;
    assign best_bcd  = r_best;

endmodule
`default_nettype wire
